// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths and source IDs for the common data bus
package cdb_arbiter_pkg;
    localparam int ROB_W_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;
endpackage

// File: rtl/cdb_fifo.sv
// rtl/cdb_fifo.sv - per-source result FIFO feeding the CDB arbiter
module cdb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push against a full FIFO is dropped even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (!do_push && do_pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin merge of ALU and LSB results onto the CDB
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              alu_s,
    input  logic [ROB_W-1:0]  alu_reorder,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_full,
    input  logic              lsb_s,
    input  logic [ROB_W-1:0]  lsb_reorder,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              lsb_full,
    output logic              cdb_s,
    output logic [ROB_W-1:0]  cdb_reorder,
    output logic [DATA_W-1:0] cdb_value,
    output logic              cdb_src
);
    localparam int W     = ROB_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     alu_head, lsb_head, alu_cand_d, lsb_cand_d;
    logic [CNT_W-1:0] alu_cnt, lsb_cnt;
    logic             active, alu_push, lsb_push, alu_ne, lsb_ne;
    logic             alu_cand, lsb_cand, grant_alu, grant_lsb;
    logic             cdb_s_q, cdb_src_q;
    logic [ROB_W-1:0] cdb_reorder_q;
    logic [DATA_W-1:0] cdb_value_q;
    src_e             rr_last_q;

    assign active   = rdy && !clr;
    assign alu_push = active && alu_s && !alu_full;
    assign lsb_push = active && lsb_s && !lsb_full;
    assign alu_ne   = (alu_cnt != '0);
    assign lsb_ne   = (lsb_cnt != '0);

    // The queued head has priority over a same-cycle push; an empty FIFO lets the push bypass.
    assign alu_cand   = active && (alu_ne || alu_push);
    assign lsb_cand   = active && (lsb_ne || lsb_push);
    assign alu_cand_d = alu_ne ? alu_head : {alu_reorder, alu_value};
    assign lsb_cand_d = lsb_ne ? lsb_head : {lsb_reorder, lsb_value};

    assign grant_lsb = lsb_cand && (!alu_cand || rr_last_q == SRC_ALU);
    assign grant_alu = alu_cand && !grant_lsb;

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_alu_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (clr),
        .push_i  (alu_push && !(grant_alu && !alu_ne)),
        .pop_i   (grant_alu && alu_ne),
        .data_i  ({alu_reorder, alu_value}),
        .head_o  (alu_head),
        .count_o (alu_cnt),
        .full_o  (alu_full)
    );

    cdb_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_lsb_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (clr),
        .push_i  (lsb_push && !(grant_lsb && !lsb_ne)),
        .pop_i   (grant_lsb && lsb_ne),
        .data_i  ({lsb_reorder, lsb_value}),
        .head_o  (lsb_head),
        .count_o (lsb_cnt),
        .full_o  (lsb_full)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cdb_s_q       <= 1'b0;
            cdb_src_q     <= 1'b0;
            cdb_reorder_q <= '0;
            cdb_value_q   <= '0;
            rr_last_q     <= SRC_LSB;
        end else if (!rdy) begin
            cdb_s_q <= 1'b0;
        end else if (grant_alu) begin
            cdb_s_q                      <= 1'b1;
            cdb_src_q                    <= SRC_ALU;
            {cdb_reorder_q, cdb_value_q} <= alu_cand_d;
            rr_last_q                    <= SRC_ALU;
        end else if (grant_lsb) begin
            cdb_s_q                      <= 1'b1;
            cdb_src_q                    <= SRC_LSB;
            {cdb_reorder_q, cdb_value_q} <= lsb_cand_d;
            rr_last_q                    <= SRC_LSB;
        end else begin
            cdb_s_q <= 1'b0;
        end
    end

    assign cdb_s       = cdb_s_q;
    assign cdb_src     = cdb_src_q;
    assign cdb_reorder = cdb_reorder_q;
    assign cdb_value   = cdb_value_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed vector and stream checks for cdb_arbiter
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        alu_s, lsb_s, alu_full, lsb_full;
    logic [3:0]  alu_reorder, lsb_reorder, cdb_reorder;
    logic [31:0] alu_value, lsb_value, cdb_value;
    logic        cdb_s, cdb_src;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.DEPTH(4), .ROB_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .alu_s(alu_s), .alu_reorder(alu_reorder), .alu_value(alu_value), .alu_full(alu_full),
        .lsb_s(lsb_s), .lsb_reorder(lsb_reorder), .lsb_value(lsb_value), .lsb_full(lsb_full),
        .cdb_s(cdb_s), .cdb_reorder(cdb_reorder), .cdb_value(cdb_value), .cdb_src(cdb_src)
    );

    typedef struct {
        logic rdy, clr, as;
        logic [3:0] at;
        logic [31:0] av;
        logic ls;
        logic [3:0] lt;
        logic [31:0] lv;
        logic es;
        logic [3:0] et;
        logic [31:0] ev;
        logic esrc, eaf, elf;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic r, logic c, logic a_s, logic [3:0] a_t, logic [31:0] a_v,
                                logic l_s, logic [3:0] l_t, logic [31:0] l_v,
                                logic e_s, logic [3:0] e_t, logic [31:0] e_v, logic e_src);
        vec_t v;
        v.rdy = r; v.clr = c; v.as = a_s; v.at = a_t; v.av = a_v;
        v.ls = l_s; v.lt = l_t; v.lv = l_v;
        v.es = e_s; v.et = e_t; v.ev = e_v; v.esrc = e_src; v.eaf = 1'b0; v.elf = 1'b0;
        return v;
    endfunction

    task automatic idle_inputs();
        rdy = 1'b1; clr = 1'b0;
        alu_s = 1'b0; alu_reorder = '0; alu_value = '0;
        lsb_s = 1'b0; lsb_reorder = '0; lsb_value = '0;
    endtask

    task automatic check_out(input string name, input logic es, input logic [3:0] et,
                             input logic [31:0] ev, input logic esrc, input logic eaf, input logic elf);
        tests++;
        if (cdb_s !== es || cdb_reorder !== et || cdb_value !== ev || cdb_src !== esrc ||
            alu_full !== eaf || lsb_full !== elf) begin
            fails++;
            $display("FAIL %s: got s=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b, expected s=%0b tag=%0d val=%h src=%0b af=%0b lf=%0b",
                     name, cdb_s, cdb_reorder, cdb_value, cdb_src, alu_full, lsb_full,
                     es, et, ev, esrc, eaf, elf);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Producers honour the full flags; expected order comes from per-source queues.
    task automatic run_stream(input string name, input int na, input int nl,
                              input int stall_mod, input int lsb_base);
        int ai = 0, li = 0, outs = 0, cyc = 0, alt_bad = 0, order_bad = 0;
        int qa[$], ql[$];
        bit afs = 0, lfs = 0;
        while (outs < na + nl && cyc < 400) begin
            rdy = (stall_mod == 0) || ((cyc % stall_mod) != stall_mod - 1);
            alu_s = rdy && (ai < na) && !alu_full;
            alu_reorder = 4'(ai); alu_value = 32'h100 + ai;
            lsb_s = rdy && (li < nl) && !lsb_full;
            lsb_reorder = 4'(lsb_base + li); lsb_value = 32'h200 + lsb_base + li;
            if (alu_s) begin qa.push_back(ai); ai++; end
            if (lsb_s) begin ql.push_back(lsb_base + li); li++; end
            @(posedge clk); #1;
            cyc++;
            if (alu_full) afs = 1;
            if (lsb_full) lfs = 1;
            if (cdb_s) begin
                if (stall_mod == 0 && cdb_src !== logic'(outs % 2)) alt_bad++;
                if (cdb_src == 1'b0) begin
                    if (qa.size() == 0 || cdb_reorder != 4'(qa[0]) || cdb_value != 32'h100 + qa[0]) order_bad++;
                    if (qa.size() != 0) void'(qa.pop_front());
                end else begin
                    if (ql.size() == 0 || cdb_reorder != 4'(ql[0]) || cdb_value != 32'h200 + ql[0]) order_bad++;
                    if (ql.size() != 0) void'(ql.pop_front());
                end
                outs++;
            end
        end
        idle_inputs();
        check_int({name, " broadcasts"}, outs, na + nl);
        check_int({name, " order errors"}, order_bad, 0);
        check_int({name, " left queued"}, qa.size() + ql.size(), 0);
        if (stall_mod == 0) begin
            check_int({name, " alternation errors"}, alt_bad, 0);
            check_int({name, " both full seen"}, int'(afs) + int'(lfs), 2);
        end
        @(posedge clk); #1;
        check_out({name, " drained idle"}, 1'b0, cdb_reorder, cdb_value, cdb_src, 1'b0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check_out("reset", 1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        vecs[0]  = mk(1,0, 1,4'd3,32'h11, 0,4'd0,32'h0,   1,4'd3,32'h11,0);
        vecs[1]  = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   0,4'd3,32'h11,0);
        vecs[2]  = mk(1,1, 0,4'd0,32'h0,  0,4'd0,32'h0,   0,4'd0,32'h0,0);
        vecs[3]  = mk(1,0, 1,4'd1,32'hA,  1,4'd2,32'hB,   1,4'd1,32'hA,0);
        vecs[4]  = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   1,4'd2,32'hB,1);
        vecs[5]  = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   0,4'd2,32'hB,1);
        vecs[6]  = mk(1,0, 1,4'd4,32'hA4, 1,4'd5,32'hA5,  1,4'd4,32'hA4,0);
        vecs[7]  = mk(1,0, 1,4'd6,32'hA6, 1,4'd7,32'hA7,  1,4'd5,32'hA5,1);
        vecs[8]  = mk(1,0, 1,4'd8,32'hA8, 1,4'd9,32'hA9,  1,4'd6,32'hA6,0);
        vecs[9]  = mk(1,0, 1,4'd10,32'hAA,1,4'd11,32'hAB, 1,4'd7,32'hA7,1);
        vecs[10] = mk(1,1, 1,4'd12,32'hAC,0,4'd0,32'h0,   0,4'd0,32'h0,0);
        vecs[11] = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   0,4'd0,32'h0,0);
        vecs[12] = mk(1,0, 1,4'd1,32'hA1, 1,4'd2,32'hA2,  1,4'd1,32'hA1,0);
        vecs[13] = mk(1,0, 1,4'd3,32'hA3, 1,4'd4,32'hA4,  1,4'd2,32'hA2,1);
        vecs[14] = mk(0,0, 1,4'd14,32'hAE,1,4'd15,32'hAF, 0,4'd2,32'hA2,1);
        vecs[15] = mk(0,0, 1,4'd14,32'hAE,0,4'd0,32'h0,   0,4'd2,32'hA2,1);
        vecs[16] = mk(0,0, 0,4'd0,32'h0,  1,4'd15,32'hAF, 0,4'd2,32'hA2,1);
        vecs[17] = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   1,4'd3,32'hA3,0);
        vecs[18] = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   1,4'd4,32'hA4,1);
        vecs[19] = mk(1,0, 0,4'd0,32'h0,  0,4'd0,32'h0,   0,4'd4,32'hA4,1);

        for (int i = 0; i < 20; i++) begin
            rdy = vecs[i].rdy; clr = vecs[i].clr;
            alu_s = vecs[i].as; alu_reorder = vecs[i].at; alu_value = vecs[i].av;
            lsb_s = vecs[i].ls; lsb_reorder = vecs[i].lt; lsb_value = vecs[i].lv;
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i), vecs[i].es, vecs[i].et, vecs[i].ev,
                      vecs[i].esrc, vecs[i].eaf, vecs[i].elf);
        end
        idle_inputs();

        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        run_stream("burst8x8", 8, 8, 0, 8);

        clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
        run_stream("wrap_lsb", 6, 10, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
